// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 4-pixel array: reset, erase, expose, ramp conversion, readout.
// Optional PIXEL_CTRL_GRAY_EN: Gray-coded conversion count, Gray->binary on capture.
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int READ_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  output logic       busy,
  output logic       pix_reset,
  output logic       erase,
  output logic       expose,
  output logic       ramp_en,
  output logic [3:0] read,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_data,
  output logic [1:0] pix_idx,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_ERASE, S_EXPOSE,
    S_CONV, S_READ, S_HOLD, S_DONE
  } state_t;

  localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0] READ_LAST   = 16'(READ_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'd255;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        pix_valid_q, pix_valid_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic [1:0]  pix_idx_q, pix_idx_d;
  logic [7:0]  captured;
  logic [7:0]  conv_code;

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

`ifdef PIXEL_CTRL_GRAY_EN
  assign captured  = gray2bin(data_i);
  assign conv_code = cnt_q[7:0] ^ (cnt_q[7:0] >> 1);
`else
  assign captured  = data_i;
  assign conv_code = cnt_q[7:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_idx_q   <= pix_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    idx_d       = idx_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_idx_d   = pix_idx_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_RST;
      end
      S_RST: begin
        cnt_d   = '0;
        state_d = S_ERASE;
      end
      S_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          cnt_d   = '0;
          state_d = S_EXPOSE;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == EXPOSE_LAST) begin
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Sample on the last settle cycle; read drops on the same edge.
        if (cnt_q == READ_LAST) begin
          cnt_d       = '0;
          pix_valid_d = 1'b1;
          pix_data_d  = captured;
          pix_idx_d   = idx_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = continuous ? S_RST : S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign pix_reset  = (state_q == S_RST);
  assign erase      = (state_q == S_ERASE);
  assign expose     = (state_q == S_EXPOSE);
  assign ramp_en    = (state_q == S_CONV);
  assign data_oe    = (state_q == S_CONV);
  assign data_o     = (state_q == S_CONV) ? conv_code : 8'd0;
  assign read       = (state_q == S_READ) ? (4'b0001 << idx_q) : 4'b0000;
  assign frame_done = (state_q == S_DONE);
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Sequencing controller for the 4-pixel `pixelArray`. It runs one frame per start command: pixel reset, erase, expose, ramp/counter conversion, then sequential readout of pixels 0..3. The shared 8-bit `data` bus is driven by the controller during conversion and by the selected pixel during readout. Each pixel value is delivered to downstream logic over a valid/ready handshake. The block sits between the analog array and the frame buffer/readout logic; the top level owns the tristate on `data`.

## Interface
- `ERASE_CYCLES`, default 5: cycles `erase` is held high; must be ≥1.
- `EXPOSE_CYCLES`, default 255: cycles `expose` is held high; must be ≥1.
- `READ_CYCLES`, default 2: settle cycles per `readN` assertion before sampling; must be ≥1.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin a frame; sampled only in IDLE.
- `continuous` input 1: when high at the end of a frame, the next frame starts without `start`.
- `busy` output 1: high in every state except IDLE.
- `pix_reset` output 1: drives the array `reset` input.
- `erase`, `expose` outputs 1 each: drive the array inputs of the same names.
- `ramp_en` output 1: high during CONVERT; starts the external analog ramp.
- `read` output 4: one-hot; bit N drives `readN`.
- `data_o` output 8: conversion count driven onto `data`.
- `data_oe` output 1: high only in CONVERT; the top level enables the tristate with it.
- `data_i` input 8: sampled `data` bus value.
- `pix_valid` output 1, `pix_ready` input 1: readout handshake.
- `pix_data` output 8, `pix_idx` output 2: captured value and pixel index.
- `frame_done` output 1: one-cycle pulse after the pixel-3 handshake.

## Operation
- States and transitions:
  - IDLE → RST when `start`.
  - RST is 1 cycle with `pix_reset`=1, then → ERASE.
  - ERASE holds `erase`=1 for ERASE_CYCLES, then → EXPOSE.
  - EXPOSE holds `expose`=1 for EXPOSE_CYCLES, then → CONVERT.
  - CONVERT runs 256 cycles, then → READ with idx=0.
  - READ → HOLD. HOLD → READ with idx+1, or → DONE after idx 3.
  - DONE is 1 cycle: `frame_done`=1. Then → RST if `continuous`, else → IDLE.
- CONVERT:
  - `ramp_en`=1, `data_oe`=1.
  - An 8-bit counter starts at 0 and increments every cycle. `data_o` = count, covering 0..255 once.
  - The counter does not wrap inside a frame; leaving CONVERT after count 255 is mandatory.
- READ:
  - `read[idx]`=1 for READ_CYCLES cycles.
  - On the last READ cycle's edge, `data_i` is captured into `pix_data`, `pix_idx`=idx, and `pix_valid` is set. `read` drops in the same edge.
- HOLD:
  - `read`=0. `pix_valid` and `pix_data` stay stable until the cycle where `pix_valid && pix_ready`.
  - `pix_valid` clears at that edge.
- `start` asserted while busy is ignored; it is not queued.
- At most one of `pix_reset`/`erase`/`expose`/`ramp_en`/`read` is active in any cycle.
- `data_oe` and any `read` bit are never high together.
- Reset mid-operation: all outputs return to idle values immediately (asynchronous). The frame is abandoned and no `frame_done` is issued.

## Timing
- Reset/idle values: `busy`=0, `pix_reset`=0, `erase`=0, `expose`=0, `ramp_en`=0, `read`=0, `data_o`=0, `data_oe`=0, `pix_valid`=0, `pix_data`=0, `pix_idx`=0, `frame_done`=0.
- Latency:
  - `start` sampled at edge T gives `pix_reset` and `busy` high after T.
  - The first `pix_valid` comes 1+ERASE_CYCLES+EXPOSE_CYCLES+256+READ_CYCLES cycles after T.
  - With `pix_ready` tied high, the frame length is 1+E+X+256+4·(READ_CYCLES+1)+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- A `continuous` frame restart enters RST the cycle after DONE, with no IDLE cycle.

## Configuration
- `PIXEL_CTRL_GRAY_EN`:
  - Defined: `data_o` carries the Gray code of the count (count ^ count>>1). Captured `data_i` is converted Gray→binary before loading `pix_data`.
  - Undefined: binary on both paths with no conversion.
  - Sequencing and timing are identical in both builds.

## Test plan
- Reset, then start pulse, with E=5, X=255, READ_CYCLES=2 and `pix_ready`=1:
  - RST 1 cycle, `erase` 5 cycles, `expose` 255 cycles, `ramp_en` 256 cycles.
  - `data_o` goes 0..255. Four `pix_valid` pulses with idx 0,1,2,3, then `frame_done`.
  - Total 1+5+255+256+12+1 = 530 cycles.
- Readout: pixel model drives `data_i`=0x33, 0x66, 0x99, 0xCC per `read` bit → `pix_data` equals those values in order. With GRAY_EN, the model drives the Gray codes 0x2A, 0x55, 0xD5, 0xAA and the same binary values are required.
- Backpressure: `pix_ready`=0 for 10 cycles on pixel 1 → `pix_valid`/`pix_data`/`pix_idx` stay stable and `read` stays 0. Pixel 2 `read` rises the cycle after the handshake.
- `start` pulsed during EXPOSE → no effect; exactly one `frame_done`. `continuous`=1 → RST follows DONE directly and `busy` never drops.
- `rst_n` low mid-CONVERT at count 100 → `ramp_en`, `data_oe`, `data_o` go to 0 immediately. After release the block stays IDLE until `start`.
- Every cycle: check one-hot exclusivity of control outputs and that `data_oe` and `read` are never both active.
